mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter MEM_SIZE, default 16384: RAM depth in 32-bit words.
REQ-003 Parameter AW, default 14: RAM word-address width, equal to log2(MEM_SIZE).
REQ-004 Port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port RST_BTN, input, 1 bit: reset, synchronous, active-low.
REQ-006 Ports c_valid (in, 1), c_addr (in, 32), c_wdata (in, 32), c_wstrb (in, 4), c_ready (out, 1), c_rdata (out, 32): CPU native memory port.
REQ-007 Ports p_valid, p_addr, p_wdata, p_wstrb, p_ready, p_rdata: peripheral (game/VGA) requester, same widths and meaning as the CPU port.
REQ-008 Ports ram_en (out, 1), ram_we (out, 4), ram_addr (out, AW), ram_wdata (out, 32), ram_rdata (in, 32): single-port synchronous RAM; read data is valid the cycle after ram_en.
REQ-009 Port grant_p (out, 1): high while the current transaction belongs to the peripheral.

Function
REQ-010 FSM states: IDLE, ACCESS, RESP.
REQ-011 IDLE: with no valid request, hold IDLE and keep ram_en=0 and ram_we=0.
REQ-012 IDLE with a valid request: pick a winner, register ram_en=1, ram_we, ram_addr and ram_wdata, then go to ACCESS.
- ram_addr = addr[AW+1:2].
- ram_we = wstrb when addr>>2 < MEM_SIZE, else 0.
REQ-013 Arbitration: round-robin, two requesters, one last_grant bit.
- On a tie, the requester not granted last wins.
- After reset, the CPU wins the first tie.
REQ-014 ACCESS lasts one cycle and always leads to RESP; ram_en and ram_we drop to 0 on that edge.
REQ-015 RESP lasts one cycle.
- The winner's ready is high, registered; the loser's ready is 0.
- Winner rdata = ram_rdata for an in-range read, 0 for a write or an out-of-range access.
- Next state: IDLE.
REQ-016 An out-of-range address SHALL complete with the normal timing and SHALL not write RAM.
REQ-017 Latency: a request sampled in IDLE at cycle N gets ready at cycle N+2; each transaction occupies 3 cycles.
REQ-018 Requesters SHALL hold valid, addr, wdata and wstrb stable until their ready.
- Valid still high in the IDLE cycle after ready counts as a new request.
REQ-019 A request arriving during ACCESS or RESP waits; the arbiter samples it in the next IDLE.
REQ-020 last_grant SHALL update on the IDLE->ACCESS edge only.
REQ-021 Outside RESP, rdata outputs SHALL be 0.
REQ-022 grant_p SHALL be high in ACCESS and RESP of a peripheral transaction, low otherwise.

Reset
REQ-023 While RST_BTN=0 at a rising edge, the block SHALL load reset values:
- state=IDLE, last_grant=peripheral (so the CPU wins the first tie);
- c_ready, p_ready, ram_en, grant_p = 0; ram_we = 0;
- ram_addr, ram_wdata = 0; c_rdata, p_rdata = 0.
REQ-024 Reset during ACCESS: the RAM operation already presented at that edge completes; no ready is issued; the requester SHALL re-issue the request.
REQ-025 Reset during RESP: ready drops on the reset edge.

Structure
REQ-026 A shared include file mem_arb_defs.vh SHALL hold the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the MEM_SIZE default.
- The same MEM_SIZE is used by the system memory map.
REQ-027 Sub-module rr_arbiter2 (combinational 2-way round-robin pick from req[1:0] and last_grant) SHALL be the only child.
REQ-028 All outputs SHALL be registered, except the rdata steering in RESP.

Verification
REQ-029 CPU-only read: preload word 5 = 32'hDEADBEEF; c_valid with c_addr=32'h14, wstrb=0 -> c_ready at N+2 with c_rdata=32'hDEADBEEF; p_ready stays 0.
REQ-030 Byte write: CPU writes c_addr=32'h20, wdata=32'h11223344, wstrb=4'b0010 to a word holding 0 -> ram_we=4'b0010 in ACCESS; a later read returns 32'h00003300.
REQ-031 Simultaneous requests: CPU and peripheral assert valid in the same IDLE cycle after reset, both held.
- CPU is served first (ready at N+2); peripheral ready at N+5.
- Repeat with both held continuously -> grants strictly alternate C,P,C,P.
REQ-032 Out of range: p_addr=32'h0001_0000 write -> p_ready at N+2, ram_we=0 throughout, p_rdata=0.
REQ-033 Reset mid-transaction: RST_BTN=0 during ACCESS of a CPU read -> no c_ready; state IDLE the next cycle; the re-issued read completes with correct data.
REQ-034 Back-to-back: CPU holds c_valid across ready with a new c_addr -> the second ready arrives exactly 3 cycles after the first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - arbiter state type and grant encodings
package mem_arbiter_pkg;
`include "mem_arb_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE   = `MEM_ARB_ST_IDLE,
    ST_ACCESS = `MEM_ARB_ST_ACCESS,
    ST_RESP   = `MEM_ARB_ST_RESP
  } state_t;

  localparam int   MEM_SIZE_DEFAULT = `MEM_ARB_MEM_SIZE;
  localparam logic GNT_CPU          = 1'b0;
  localparam logic GNT_PERIPH       = 1'b1;
endpackage

// File: rtl/mem_arb_defs.vh
// rtl/mem_arb_defs.vh - shared arbiter state encodings and memory depth
`ifndef MEM_ARB_DEFS_VH
`define MEM_ARB_DEFS_VH

`define MEM_ARB_ST_IDLE   2'd0
`define MEM_ARB_ST_ACCESS 2'd1
`define MEM_ARB_ST_RESP   2'd2
`define MEM_ARB_MEM_SIZE  16384

`endif

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pick; gnt=1 selects req[1]
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt
);
  assign gnt_valid = |req;
  assign gnt       = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/peripheral round-robin arbiter onto one single-port RAM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter int AW       = 14
) (
  input  logic          CLK,
  input  logic          RST_BTN,
  input  logic          c_valid,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [3:0]    c_wstrb,
  output logic          c_ready,
  output logic [31:0]   c_rdata,
  input  logic          p_valid,
  input  logic [31:0]   p_addr,
  input  logic [31:0]   p_wdata,
  input  logic [3:0]    p_wstrb,
  output logic          p_ready,
  output logic [31:0]   p_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          grant_p
);
  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  logic        rd_ok;
  logic        win_valid;
  logic        win;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        in_range;

  rr_arbiter2 u_rr (
    .req        ({p_valid, c_valid}),
    .last_grant (last_grant),
    .gnt_valid  (win_valid),
    .gnt        (win)
  );

  assign sel_addr  = win ? p_addr  : c_addr;
  assign sel_wdata = win ? p_wdata : c_wdata;
  assign sel_wstrb = win ? p_wstrb : c_wstrb;
  assign in_range  = (sel_addr >> 2) < 32'(MEM_SIZE);

  always_ff @(posedge CLK) begin
    if (!RST_BTN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      last_grant <= GNT_PERIPH;
      owner      <= GNT_CPU;
      rd_ok      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 4'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
      c_ready    <= 1'b0;
      p_ready    <= 1'b0;
      grant_p    <= 1'b0;
    end else begin
      c_ready <= 1'b0;
      p_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            ram_en     <= 1'b1;
            ram_we     <= in_range ? sel_wstrb : 4'b0;
            ram_addr   <= sel_addr[AW+1:2];
            ram_wdata  <= sel_wdata;
            last_grant <= win;
            owner      <= win;
            grant_p    <= win;
            rd_ok      <= in_range && (sel_wstrb == 4'b0);
          end
        end
        ST_ACCESS: begin
          ram_en  <= 1'b0;
          ram_we  <= 4'b0;
          c_ready <= (owner == GNT_CPU);
          p_ready <= (owner == GNT_PERIPH);
        end
        ST_RESP: grant_p <= 1'b0;
        default: ;
      endcase
    end
  end

  // RAM read data only exists in RESP, so rdata is steered combinationally there
  always_comb begin
    c_rdata = 32'h0;
    p_rdata = 32'h0;
    if (state == ST_RESP && rd_ok) begin
      if (owner == GNT_CPU) c_rdata = ram_rdata;
      else                  p_rdata = ram_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory model
module tb_mem_arbiter;
  localparam int MEM_SIZE = 16384;
  localparam int AW       = 14;

  logic          CLK = 1'b0;
  logic          RST_BTN = 1'b0;
  logic          c_valid = 1'b0;
  logic [31:0]   c_addr = 32'h0, c_wdata = 32'h0;
  logic [3:0]    c_wstrb = 4'h0;
  logic          c_ready;
  logic [31:0]   c_rdata;
  logic          p_valid = 1'b0;
  logic [31:0]   p_addr = 32'h0, p_wdata = 32'h0;
  logic [3:0]    p_wstrb = 4'h0;
  logic          p_ready;
  logic [31:0]   p_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;
  logic          grant_p;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} txn_t;
  typedef struct {bit who; logic [31:0] rdata; int cyc;} resp_t;
  typedef struct {int cyc; logic [3:0] we; bit who;} acc_t;

  resp_t       sb[$];
  acc_t        accq[$];
  txn_t        cq[$], pq[$];
  resp_t       mon_r;
  logic [31:0] mem     [0:MEM_SIZE-1];
  logic [31:0] ref_mem [0:MEM_SIZE-1];
  bit          model_last = 1'b1;
  int          free_cyc = 0;

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .AW(AW)) dut (
    .CLK(CLK), .RST_BTN(RST_BTN),
    .c_valid(c_valid), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_ready(c_ready), .c_rdata(c_rdata),
    .p_valid(p_valid), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstrb(p_wstrb),
    .p_ready(p_ready), .p_rdata(p_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant_p(grant_p)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pattern(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 8) return 32'h0;
    return (32'(i) * 32'h01030507) ^ 32'hA5C30000;
  endfunction

  // single-port synchronous RAM, read-before-write
  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = pattern(i);
    forever begin
      @(posedge CLK);
      if (ram_en) begin
        ram_rdata = mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (c_ready === 1'b1 || p_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got c_ready=%b p_ready=%b expected none at cycle %0d", c_ready, p_ready, cyc);
      end else begin
        mon_r = sb.pop_front();
        check("ready_port", 32'(p_ready), 32'(mon_r.who));
        check("ready_excl", 32'(c_ready & p_ready), 32'h0);
        check("ready_cycle", 32'(cyc), 32'(mon_r.cyc));
        check("winner_rdata", mon_r.who ? p_rdata : c_rdata, mon_r.rdata);
        check("loser_rdata", mon_r.who ? c_rdata : p_rdata, 32'h0);
        check("grant_p_resp", 32'(grant_p), 32'(mon_r.who));
      end
    end else begin
      check("idle_c_rdata", c_rdata, 32'h0);
      check("idle_p_rdata", p_rdata, 32'h0);
    end
  end

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t x;
    x.addr = a; x.wdata = d; x.wstrb = s;
    return x;
  endfunction

  // memory semantics: in-range reads return the word, in-range writes merge bytes, out-of-range is dropped
  task automatic predict(input txn_t x, output logic [3:0] we, output logic [31:0] rd);
    int idx;
    bit ok;
    idx = int'(x.addr[15:2]);
    ok  = (x.addr >> 2) < 32'(MEM_SIZE);
    we  = ok ? x.wstrb : 4'b0;
    rd  = 32'h0;
    if (ok && x.wstrb == 4'b0) rd = ref_mem[idx];
    else if (ok)
      for (int b = 0; b < 4; b++)
        if (x.wstrb[b]) ref_mem[idx][8*b +: 8] = x.wdata[8*b +: 8];
  endtask

  task automatic serve();
    int t, ci, pi, budget;
    bit w;
    txn_t x;
    logic [3:0] we;
    logic [31:0] rd;
    acc_t a;
    ci = 0; pi = 0;
    while (cyc < free_cyc) @(negedge CLK);
    t = cyc;
    // both pending -> the one not served last; otherwise the lone requester; 3 cycles each
    while (ci < cq.size() || pi < pq.size()) begin
      if (ci < cq.size() && pi < pq.size()) w = !model_last;
      else w = (pi < pq.size());
      if (w) begin x = pq[pi]; pi++; end
      else begin x = cq[ci]; ci++; end
      predict(x, we, rd);
      sb.push_back('{w, rd, t + 2});
      accq.push_back('{t + 1, we, w});
      model_last = w;
      t += 3;
    end
    budget = t - cyc + 10;
    if (cq.size() > 0) begin c_addr = cq[0].addr; c_wdata = cq[0].wdata; c_wstrb = cq[0].wstrb; c_valid = 1'b1; end
    if (pq.size() > 0) begin p_addr = pq[0].addr; p_wdata = pq[0].wdata; p_wstrb = pq[0].wstrb; p_valid = 1'b1; end
    while ((cq.size() > 0 || pq.size() > 0) && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (accq.size() > 0 && accq[0].cyc == cyc) begin
        a = accq.pop_front();
        check("access_ram_en", 32'(ram_en), 32'h1);
        check("access_ram_we", 32'(ram_we), 32'(a.we));
        check("access_grant_p", 32'(grant_p), 32'(a.who));
      end
      if (c_ready === 1'b1 && cq.size() > 0) begin
        void'(cq.pop_front());
        if (cq.size() > 0) begin c_addr = cq[0].addr; c_wdata = cq[0].wdata; c_wstrb = cq[0].wstrb; end
        else c_valid = 1'b0;
      end
      if (p_ready === 1'b1 && pq.size() > 0) begin
        void'(pq.pop_front());
        if (pq.size() > 0) begin p_addr = pq[0].addr; p_wdata = pq[0].wdata; p_wstrb = pq[0].wstrb; end
        else p_valid = 1'b0;
      end
    end
    if (cq.size() > 0 || pq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: got %0d cpu and %0d periph pending, expected 0", cq.size(), pq.size());
      cq.delete(); pq.delete(); sb.delete(); accq.delete();
      c_valid = 1'b0; p_valid = 1'b0;
    end
    free_cyc = cyc + 1;
  endtask

  function automatic txn_t rand_txn();
    logic [31:0] w4, base;
    int sel;
    w4  = 32'($urandom_range(0, 15)) << 2;
    sel = int'($urandom_range(0, 7));
    base = (sel == 0) ? 32'h0001_0000 : (sel == 1) ? 32'hF000_0000 : 32'h0;
    return mk(base + w4, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pattern(i);
    repeat (3) @(negedge CLK);
    check("rst_c_ready", 32'(c_ready), 32'h0);
    check("rst_p_ready", 32'(p_ready), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_grant_p", 32'(grant_p), 32'h0);
    RST_BTN = 1'b1;
    model_last = 1'b1;
    free_cyc = cyc;

    cq.push_back(mk(32'h40, 32'h0, 4'h0));
    pq.push_back(mk(32'h44, 32'h0, 4'h0));
    serve();
    for (int i = 0; i < 2; i++) begin
      cq.push_back(mk(32'h48 + 32'(8 * i), 32'h0, 4'h0));
      pq.push_back(mk(32'h4C + 32'(8 * i), 32'h0, 4'h0));
    end
    serve();

    cq.push_back(mk(32'h14, 32'h0, 4'h0));
    serve();
    cq.push_back(mk(32'h20, 32'h11223344, 4'b0010));
    serve();
    cq.push_back(mk(32'h20, 32'h0, 4'h0));
    serve();

    pq.push_back(mk(32'h0001_0000, 32'hCAFEF00D, 4'hF));
    serve();
    pq.push_back(mk(32'h0, 32'h0, 4'h0));
    serve();

    cq.push_back(mk(32'h14, 32'h0, 4'h0));
    cq.push_back(mk(32'h24, 32'h0, 4'h0));
    serve();

    while (cyc < free_cyc) @(negedge CLK);
    c_addr = 32'h1C; c_wdata = 32'h0; c_wstrb = 4'h0; c_valid = 1'b1;
    @(negedge CLK);
    check("rst_mid_access_en", 32'(ram_en), 32'h1);
    RST_BTN = 1'b0;
    @(negedge CLK);
    check("rst_mid_c_ready", 32'(c_ready), 32'h0);
    check("rst_mid_ram_en", 32'(ram_en), 32'h0);
    check("rst_mid_grant_p", 32'(grant_p), 32'h0);
    RST_BTN = 1'b1;
    model_last = 1'b1;
    free_cyc = cyc;
    cq.push_back(mk(32'h1C, 32'h0, 4'h0));
    serve();

    repeat (40) begin
      int nc, np;
      nc = int'($urandom_range(0, 3));
      np = int'($urandom_range(0, 3));
      if (nc + np == 0) nc = 1;
      for (int i = 0; i < nc; i++) cq.push_back(rand_txn());
      for (int i = 0; i < np; i++) pq.push_back(rand_txn());
      serve();
    end

    repeat (3) @(negedge CLK);
    if (sb.size() != 0 || accq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expect: got %0d responses %0d accesses outstanding, expected 0", sb.size(), accq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
